// File: rtl/mccpu_mem_pkg.sv
// Shared types and defaults for the multi-cycle CPU memory responder.
// Holds FSM encoding, error causes and the latched request bundle.
package mccpu_mem_pkg;

  localparam int unsigned AW_DEF  = 10;
  localparam int unsigned LAT_DEF = 2;
  localparam int unsigned CW      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_RANGE = 2'b10
  } err_cause_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  // Over-range addresses are rejected, never aliased.
  function automatic err_cause_e err_cause(
    input logic [31:0] a,
    input int unsigned aw
  );
    err_cause_e c;
    c = ERR_NONE;
    if (a[1:0] != 2'b00)
      c = ERR_ALIGN;
    else if ((a >> (aw + 2)) != 32'd0)
      c = ERR_RANGE;
    return c;
  endfunction

endpackage

// File: rtl/mccpu_mem_slave_if.sv
// Request/response bundle between the CPU controller and the memory.
// The master holds all request fields stable until ready.
interface mccpu_mem_slave_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ready, err, busy
  );

endinterface

// File: rtl/mccpu_mem_array.sv
// Word-organised storage with byte-enabled synchronous write.
// Read port is combinational; contents are never reset.
module mccpu_mem_array
  import mccpu_mem_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i])
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mccpu_mem_slave.sv
// Memory responder: latches one request, waits LATENCY cycles,
// then answers for one cycle and commits any write at its end.
module mccpu_mem_slave
  import mccpu_mem_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned LATENCY = LAT_DEF
) (
  input logic               clk,
  input logic               rst,
  mccpu_mem_slave_if.slave  bus
);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  mem_req_t       req_q, req_d;

  err_cause_e     cause;
  logic           in_resp;
  logic           bad;
  logic [31:0]    arr_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          req_d.we    = bus.we;
          req_d.addr  = bus.addr;
          req_d.wdata = bus.wdata;
          req_d.be    = bus.be;
          cnt_d       = CW'(LATENCY - 1);
          state_d     = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cause   = err_cause(req_q.addr, AW);
  assign in_resp = (state_q == RESP);
  assign bad     = (cause != ERR_NONE);

  assign bus.ready = in_resp;
  assign bus.err   = in_resp & bad;
  assign bus.busy  = (state_q != IDLE);
  assign bus.rdata = (in_resp && !bad) ? arr_rdata : 32'd0;

  // Write lands on the edge that closes RESP, so RESP reads see old data.
  mccpu_mem_array #(
    .AW (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (in_resp & req_q.we & ~bad),
    .waddr_i (req_q.addr[AW+1:2]),
    .wdata_i (req_q.wdata),
    .be_i    (req_q.be),
    .raddr_i (req_q.addr[AW+1:2]),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_mccpu_mem_slave.sv
// Randomised bench for mccpu_mem_slave against a word-array model.
// Covers directed plan items plus latency sweeps at 1 and 15.
module tb_mccpu_mem_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  mccpu_mem_slave_if b2 ();
  mccpu_mem_slave_if b1 ();
  mccpu_mem_slave_if b15 ();

  mccpu_mem_slave #(.AW(10), .LATENCY(2)) dut (
    .clk (clk), .rst (rst), .bus (b2)
  );
  mccpu_mem_slave #(.AW(10), .LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (b1)
  );
  mccpu_mem_slave #(.AW(10), .LATENCY(15)) dut15 (
    .clk (clk), .rst (rst), .bus (b15)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic txn(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  be,
    output logic [31:0] rd,
    output logic        er
  );
    int          k;
    logic        exp_err;
    logic [31:0] exp_rd;
    exp_err = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    exp_rd  = exp_err ? 32'd0 : ref_mem[a[11:2]];
    @(negedge clk);
    b2.req = 1'b1; b2.we = w; b2.addr = a;
    b2.wdata = wd; b2.be = be;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("busy", 32'(b2.busy), 32'd1);
    end while (!b2.ready && k < 40);
    rd = b2.rdata;
    er = b2.err;
    b2.req = 1'b0;
    chk("latency", k, 2);
    chk("err", 32'(er), 32'(exp_err));
    if (!w) chk("rdata", rd, exp_rd);
    if (w && !exp_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[a[11:2]][8*i +: 8] = wd[8*i +: 8];
  endtask

  function automatic logic rdy(int s);
    return (s == 1) ? b1.ready : b15.ready;
  endfunction

  function automatic logic erx(int s);
    return (s == 1) ? b1.err : b15.err;
  endfunction

  task automatic sweep(int lat);
    int k;
    @(negedge clk);
    if (lat == 1) b1.req = 1'b1;
    else          b15.req = 1'b1;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rdy(lat) && k < 40);
    chk($sformatf("lat%0d", lat), k, lat);
    chk($sformatf("lat%0d_err", lat), 32'(erx(lat)), 32'd0);
    for (int p = 0; p < 3; p++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!rdy(lat) && k < 40);
      chk($sformatf("period%0d", lat), k, lat + 1);
    end
    b1.req  = 1'b0;
    b15.req = 1'b0;
    repeat (lat + 3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, a, wd, old;
    logic        er, seen;
    int          idx, sel;

    b2.req = 0;  b2.we = 0;  b2.addr = 0;  b2.wdata = 0;  b2.be = 0;
    b1.req = 0;  b1.we = 0;  b1.addr = 0;  b1.wdata = 0;  b1.be = 0;
    b15.req = 0; b15.we = 0; b15.addr = 0; b15.wdata = 0; b15.be = 0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(b2.ready), 32'd0);
    chk("rst_err", 32'(b2.err), 32'd0);
    chk("rst_busy", 32'(b2.busy), 32'd0);
    chk("rst_rdata", b2.rdata, 32'd0);
    rst = 1'b1;

    for (int p = 0; p < 32; p++) begin
      idx = (p < 16) ? p : 1008 + p - 16;
      txn(1'b1, 32'(idx) << 2, $urandom, 4'hF, rd, er);
    end

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
    chk("wr10_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10, 32'd0, 4'h0, rd, er);
    chk("rd10", rd, 32'hDEADBEEF);

    txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er);
    txn(1'b0, 32'h20, 32'd0, 4'h0, rd, er);
    chk("partial", rd, 32'h11BB33DD);

    txn(1'b0, 32'h22, 32'd0, 4'h0, rd, er);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    txn(1'b0, 32'h20, 32'd0, 4'h0, rd, er);
    chk("mis_keep", rd, 32'h11BB33DD);

    old = ref_mem[0];
    txn(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, rd, er);
    chk("oor_err", 32'(er), 32'd1);
    txn(1'b0, 32'h0, 32'd0, 4'h0, rd, er);
    chk("oor_noalias", rd, old);

    txn(1'b1, 32'h44, 32'h0, 4'b0000, rd, er);
    chk("be0_err", 32'(er), 32'd0);

    old = ref_mem[12];
    @(negedge clk);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h30;
    b2.wdata = ~old; b2.be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_busy", 32'(b2.busy), 32'd0);
    b2.req = 1'b0;
    seen = b2.ready;
    repeat (4) begin
      @(negedge clk);
      seen = seen | b2.ready;
    end
    chk("mid_noready", 32'(seen), 32'd0);
    rst = 1'b1;
    txn(1'b0, 32'h30, 32'd0, 4'h0, rd, er);
    chk("mid_old", rd, old);

    sweep(1);
    sweep(15);

    for (int n = 0; n < 120; n++) begin
      idx = $urandom % 32;
      idx = (idx < 16) ? idx : 1008 + idx - 16;
      a   = 32'(idx) << 2;
      sel = $urandom % 8;
      if (sel == 0)
        a = a + 32'($urandom_range(1, 3));
      else if (sel == 1)
        a = a | (32'h1 << (12 + ($urandom % 20)));
      wd = $urandom;
      txn(1'($urandom % 2), a, wd, 4'($urandom % 16), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
